// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory port, with an ack timeout.
// Define MEM_ARB_FAIRNESS_EN to make contention alternate between the sides instead of favouring the data side.
module rv32i_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ready,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_wstrb,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_grant_dm,
  output logic        o_bus_err
);

  // state | meaning
  // IDLE  | no transfer; requests sampled and winner latched onto the memory port
  // BUSY  | o_mem_req high, waiting for ack or timeout
  // RESP  | one-cycle ready pulse to the owner; requests ignored
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic             grant_dm_q, grant_dm_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             dm_ready_q, dm_ready_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dm_wins;

`ifdef MEM_ARB_FAIRNESS_EN
  logic             last_dm_q, last_dm_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    grant_dm_d  = grant_dm_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_FAIRNESS_EN
    last_dm_d   = last_dm_q;
    dm_wins     = i_dm_req && (!i_if_req || !last_dm_q);
`else
    dm_wins     = i_dm_req;
`endif

    case (state_q)
      IDLE: begin
        grant_dm_d = 1'b0;
        if (i_if_req || i_dm_req) begin
          state_d    = BUSY;
          mem_req_d  = 1'b1;
          grant_dm_d = dm_wins;
          cnt_d      = '0;
`ifdef MEM_ARB_FAIRNESS_EN
          last_dm_d  = dm_wins;
`endif
          if (dm_wins) begin
            mem_we_d    = i_dm_we;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
            mem_wstrb_d = i_dm_wstrb;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = 4'b0000;
          end
        end
      end

      BUSY: begin
        // ack wins over a timeout landing on the same edge
        if (i_mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (grant_dm_q) begin
            dm_rdata_d = mem_we_q ? 32'h0 : i_mem_rdata;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = i_mem_rdata;
            if_ready_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (grant_dm_q) begin
            dm_rdata_d = 32'h0;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = 32'h0;
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d    = IDLE;
        grant_dm_d = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        grant_dm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_dm_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      grant_dm_q  <= grant_dm_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) last_dm_q <= 1'b0;
    else       last_dm_q <= last_dm_d;
  end
`endif

  assign o_if_rdata  = if_rdata_q;
  assign o_if_ready  = if_ready_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_dm_ready  = dm_ready_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_busy      = (state_q != IDLE);
  assign o_grant_dm  = grant_dm_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: directed transfers push expected responses, a monitor checks each ready pulse.
module tb_rv32i_mem_arbiter;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ready;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_wstrb;
  logic [31:0] o_dm_rdata;
  logic        o_dm_ready;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_busy;
  logic        o_grant_dm;
  logic        o_bus_err;

  rv32i_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_wstrb(i_dm_wstrb),
    .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_busy(o_busy), .o_grant_dm(o_grant_dm), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic is_dm, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  function automatic logic any_out();
    return |{o_if_rdata, o_if_ready, o_dm_rdata, o_dm_ready, o_mem_req, o_mem_we,
             o_mem_addr, o_mem_wdata, o_mem_wstrb, o_busy, o_grant_dm, o_bus_err};
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_if_ready || o_dm_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b with nothing outstanding", o_if_ready, o_dm_ready);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_side_dm", {31'b0, o_dm_ready}, {31'b0, e.is_dm});
        check("ready_single", {31'b0, o_if_ready & o_dm_ready}, 32'h0);
        check("resp_rdata", e.is_dm ? o_dm_rdata : o_if_rdata, e.rdata);
        check("resp_bus_err", {31'b0, o_bus_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        held_ok;
    logic        exp_dm;
    logic        fair;
    int          nbusy;

    i_rst = 1'b1; i_if_req = 0; i_if_addr = 0; i_dm_req = 0; i_dm_we = 0;
    i_dm_addr = 0; i_dm_wdata = 0; i_dm_wstrb = 0; i_mem_rdata = 0; i_mem_ack = 0;
    repeat (3) tick;
    i_rst = 1'b0;
    check("reset_outputs_zero", {31'b0, any_out()}, 32'h0);

    // Single fetch, ack in the first BUSY cycle
    i_if_req = 1; i_if_addr = 32'h0000_0100;
    push_exp(1'b0, 32'h0050_0093, 1'b0);
    tick;
    check("fetch_mem_req", {31'b0, o_mem_req}, 32'h1);
    check("fetch_mem_addr", o_mem_addr, 32'h0000_0100);
    check("fetch_mem_we", {31'b0, o_mem_we}, 32'h0);
    check("fetch_mem_wstrb", {28'b0, o_mem_wstrb}, 32'h0);
    check("fetch_grant_dm", {31'b0, o_grant_dm}, 32'h0);
    check("fetch_busy", {31'b0, o_busy}, 32'h1);
    i_mem_ack = 1; i_mem_rdata = 32'h0050_0093;
    tick;
    check("fetch_ready_latency", {31'b0, o_if_ready}, 32'h1);
    check("fetch_req_dropped", {31'b0, o_mem_req}, 32'h0);
    check("resp_busy", {31'b0, o_busy}, 32'h1);
    i_mem_ack = 0; i_if_req = 0;
    tick;
    check("fetch_ready_one_cycle", {31'b0, o_if_ready}, 32'h0);
    check("idle_not_busy", {31'b0, o_busy}, 32'h0);
    check("fetch_rdata_hold", o_if_rdata, 32'h0050_0093);

    // Store, ack in the fifth BUSY cycle
    i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h0000_2000;
    i_dm_wdata = 32'hDEAD_BEEF; i_dm_wstrb = 4'b0011; i_mem_rdata = 32'h1234_5678;
    push_exp(1'b1, 32'h0, 1'b0);
    tick;
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!(o_mem_req && o_mem_we && o_mem_addr == 32'h2000 && o_mem_wdata == 32'hDEAD_BEEF
            && o_mem_wstrb == 4'b0011 && o_grant_dm)) held_ok = 1'b0;
      if (c == 4) i_mem_ack = 1;
      tick;
    end
    check("store_mem_port_held", {31'b0, held_ok}, 32'h1);
    check("store_dm_ready", {31'b0, o_dm_ready}, 32'h1);
    check("store_grant_dm_resp", {31'b0, o_grant_dm}, 32'h1);
    i_mem_ack = 0; i_dm_req = 0; i_dm_we = 0;
    tick;
    check("idle_grant_dm_zero", {31'b0, o_grant_dm}, 32'h0);
    check("if_rdata_unchanged_by_dm", o_if_rdata, 32'h0050_0093);

    // Reset so contention starts from a clean arbitration history
    i_rst = 1; tick; i_rst = 0;
    check("reset2_outputs_zero", {31'b0, any_out()}, 32'h0);

`ifdef MEM_ARB_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    i_if_req = 1; i_if_addr = 32'h0000_0400;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h0000_0500; i_dm_wstrb = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      exp_dm = !(fair && k == 1);
      push_exp(exp_dm, 32'h0000_1000 + 32'(k), 1'b0);
      tick;
      check("contend_grant_dm", {31'b0, o_grant_dm}, {31'b0, exp_dm});
      check("contend_mem_addr", o_mem_addr, exp_dm ? 32'h500 : 32'h400);
      i_mem_ack = 1; i_mem_rdata = 32'h0000_1000 + 32'(k);
      tick;
      i_mem_ack = 0;
      tick;
    end
    i_if_req = 0; i_dm_req = 0;

    // Timeout on a fetch
    i_if_req = 1; i_if_addr = 32'h0000_0600; i_mem_rdata = 32'hFFFF_FFFF;
    push_exp(1'b0, 32'h0, 1'b1);
    tick;
    nbusy = 0;
    for (int c = 0; c < TO; c++) begin
      if (o_mem_req) nbusy++;
      tick;
    end
    check("timeout_busy_cycles", 32'(nbusy), 32'(TO));
    check("timeout_req_dropped", {31'b0, o_mem_req}, 32'h0);
    check("timeout_bus_err", {31'b0, o_bus_err}, 32'h1);
    i_if_req = 0;
    tick;
    i_mem_ack = 1;
    tick;
    tick;
    i_mem_ack = 0;
    check("late_ack_idle", {31'b0, o_busy | o_mem_req | o_bus_err}, 32'h0);
    check("late_ack_if_rdata", o_if_rdata, 32'h0);

    // Ack on the last BUSY cycle before timeout
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h0000_0700; i_mem_rdata = 32'h0BAD_CAFE;
    push_exp(1'b1, 32'h0BAD_CAFE, 1'b0);
    tick;
    repeat (TO - 1) tick;
    check("boundary_still_req", {31'b0, o_mem_req}, 32'h1);
    i_mem_ack = 1;
    tick;
    check("boundary_dm_ready", {31'b0, o_dm_ready}, 32'h1);
    check("boundary_no_err", {31'b0, o_bus_err}, 32'h0);
    i_mem_ack = 0; i_dm_req = 0;
    tick;

    // Reset during the second BUSY cycle, then a stray ack
    i_if_req = 1; i_if_addr = 32'h0000_0800;
    tick;
    tick;
    i_rst = 1;
    tick;
    i_rst = 0; i_if_req = 0; i_mem_ack = 1; i_mem_rdata = 32'h5555_5555;
    tick;
    check("reset_midbusy_zero", {31'b0, any_out()}, 32'h0);
    i_mem_ack = 0;
    tick;
    check("reset_midbusy_stays_idle", {31'b0, any_out()}, 32'h0);

    // A request pulse that falls between edges is never granted
    i_dm_req = 1; i_dm_addr = 32'h0000_0900;
    #2;
    i_dm_req = 0;
    tick;
    check("dropped_req_no_access", {31'b0, o_mem_req | o_busy}, 32'h0);

    repeat (3) tick;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
